// File: rtl/connect4_pkg.sv
// Purpose: shared constants, state encodings and move payload for the
//          connect4 input path.
// Contents: NUM_COLS, COL_W, KEY_W, KEY_MIN/KEY_MAX, state_t, move_cmd_t,
//           key_legal()/key_to_col() helpers.
package connect4_pkg;

  localparam int unsigned NUM_COLS = 7;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned KEY_W    = 4;

  localparam logic [KEY_W-1:0] KEY_MIN = 4'h1;
  localparam logic [KEY_W-1:0] KEY_MAX = KEY_W'(NUM_COLS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic             pop;
  } move_cmd_t;

  // Key codes 1..NUM_COLS select a column; everything else is rejected.
  function automatic logic key_legal(input logic [KEY_W-1:0] code);
    return (code >= KEY_MIN) && (code <= KEY_MAX);
  endfunction

  function automatic logic [COL_W-1:0] key_to_col(input logic [KEY_W-1:0] code);
    return COL_W'(code - KEY_MIN);
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Purpose: move command handshake between the input controller and the
//          game logic.
// Signals: move_valid/move_col/move_pop (command, from controller),
//          move_ack/game_ready (from game logic).
// Modports: master = input controller, slave = game logic.
interface move_input_ctrl_if;
  import connect4_pkg::*;

  logic             move_valid;
  logic [COL_W-1:0] move_col;
  logic             move_pop;
  logic             move_ack;
  logic             game_ready;

  modport master (
    output move_valid, move_col, move_pop,
    input  move_ack, game_ready
  );

  modport slave (
    input  move_valid, move_col, move_pop,
    output move_ack, game_ready
  );

endinterface

// File: rtl/rise_edge.sv
// Purpose: registered rising-edge detector for a synchronous 1-bit level.
// Ports: clk, clr_n (async active-low reset), din (level),
//        rise (1-cycle registered pulse, one clk after din goes high).
module rise_edge (
  input  logic clk,
  input  logic clr_n,
  input  logic din,
  output logic rise
);

  logic prev;

  // prev clears on reset so a level already high at release counts as an edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= din;
      rise <= din & ~prev;
    end
  end

endmodule

// File: rtl/move_input_ctrl.sv
// Purpose: turns keypad column codes, pop level and the submit button into one
//          move command per turn, issued over a valid/ack handshake, and
//          exports the pending column selection for the cursor highlight.
// Ports:
//   clk, clr_n          clock, async active-low reset
//   key_code/key_strobe decoded key value and its 1-cycle strobe
//   pop_in              pop-mode level, sampled when a move is latched
//   submit              debounced submit button level
//   mv (master)         move_valid/move_col/move_pop out, move_ack/game_ready in
//   sel_valid/sel_col   current column selection
//   err_pulse           1-cycle pulse on rejected input
// Build option: SELECT_TIMEOUT_EN drops an unused selection after
//   TIMEOUT_CYCLES clocks in SEL; undefined means selections never expire.
module move_input_ctrl
  import connect4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [KEY_W-1:0]   key_code,
  input  logic               key_strobe,
  input  logic               pop_in,
  input  logic               submit,
  move_input_ctrl_if.master  mv,
  output logic               sel_valid,
  output logic [COL_W-1:0]   sel_col,
  output logic               err_pulse
);

  state_t    state;
  logic      move_valid_q;
  move_cmd_t move_q;
  logic      submit_rise;
  logic      key_ok_c;
  logic      key_bad_c;
  logic      expire_c;

  rise_edge u_submit_edge (
    .clk   (clk),
    .clr_n (clr_n),
    .din   (submit),
    .rise  (submit_rise)
  );

  assign key_ok_c  = key_strobe &  key_legal(key_code);
  assign key_bad_c = key_strobe & ~key_legal(key_code);

`ifdef SELECT_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] sel_cnt;

  assign expire_c = (state == ST_SEL) && (sel_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Selection age; held at zero outside SEL so SEL always starts from zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sel_cnt <= '0;
    end else if ((state != ST_SEL) || (key_ok_c && !submit_rise)) begin
      sel_cnt <= '0;
    end else if (!expire_c) begin
      sel_cnt <= sel_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign expire_c       = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Input FSM with registered selection, move and error outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= ST_IDLE;
      sel_valid    <= 1'b0;
      sel_col      <= '0;
      err_pulse    <= 1'b0;
      move_valid_q <= 1'b0;
      move_q       <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_ok_c) begin
            state     <= ST_SEL;
            sel_valid <= 1'b1;
            sel_col   <= key_to_col(key_code);
          end
          if (key_bad_c || submit_rise) begin
            err_pulse <= 1'b1;
          end
        end

        ST_SEL: begin
          // Submit outranks a same-cycle key, which is dropped silently.
          if (submit_rise && mv.game_ready) begin
            state        <= ST_REQ;
            move_valid_q <= 1'b1;
            move_q.col   <= sel_col;
            move_q.pop   <= pop_in;
          end else if (submit_rise) begin
            err_pulse <= 1'b1;
          end else if (key_ok_c) begin
            sel_col <= key_to_col(key_code);
          end else if (expire_c) begin
            state     <= ST_IDLE;
            sel_valid <= 1'b0;
            err_pulse <= 1'b1;
          end else if (key_bad_c) begin
            err_pulse <= 1'b1;
          end
        end

        ST_REQ: begin
          // Keys and submits are ignored until the game consumes the move.
          if (mv.move_ack) begin
            state        <= ST_IDLE;
            move_valid_q <= 1'b0;
            sel_valid    <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mv.move_valid = move_valid_q;
  assign mv.move_col   = move_q.col;
  assign mv.move_pop   = move_q.pop;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Purpose: directed self-checking bench for move_input_ctrl.
// Build option: define SELECT_TIMEOUT_EN to exercise selection expiry
//   (DUT built with TIMEOUT_CYCLES=8); otherwise checks the selection persists.
module tb_move_input_ctrl;
  import connect4_pkg::*;

  logic             clk;
  logic             clr_n;
  logic [KEY_W-1:0] key_code;
  logic             key_strobe;
  logic             pop_in;
  logic             submit;
  logic             sel_valid;
  logic [COL_W-1:0] sel_col;
  logic             err_pulse;

  int n_checks = 0;
  int n_err    = 0;

  move_input_ctrl_if mif ();

  move_input_ctrl #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .pop_in     (pop_in),
    .submit     (submit),
    .mv         (mif),
    .sel_valid  (sel_valid),
    .sel_col    (sel_col),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [KEY_W-1:0] code);
    key_code   = code;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
  endtask

  initial begin
    clr_n          = 1'b0;
    key_code       = '0;
    key_strobe     = 1'b0;
    pop_in         = 1'b0;
    submit         = 1'b0;
    mif.move_ack   = 1'b0;
    mif.game_ready = 1'b0;
    #1;
    check("rst_move_valid", 32'(mif.move_valid), 32'd0);
    check("rst_move_col",   32'(mif.move_col),   32'd0);
    check("rst_move_pop",   32'(mif.move_pop),   32'd0);
    check("rst_sel_valid",  32'(sel_valid),      32'd0);
    check("rst_sel_col",    32'(sel_col),        32'd0);
    check("rst_err",        32'(err_pulse),      32'd0);
    tick();
    tick();
    clr_n = 1'b1;

    // 1: key 3, submit, move on column 2 two clocks after the edge
    mif.game_ready = 1'b1;
    press_key(4'h3);
    check("t1_sel_valid", 32'(sel_valid), 32'd1);
    check("t1_sel_col",   32'(sel_col),   32'd2);
    check("t1_no_err",    32'(err_pulse), 32'd0);
    submit = 1'b1;
    tick();
    check("t1_lat1_valid", 32'(mif.move_valid), 32'd0);
    tick();
    submit = 1'b0;
    check("t1_lat2_valid", 32'(mif.move_valid), 32'd1);
    check("t1_move_col",   32'(mif.move_col),   32'd2);
    check("t1_move_pop",   32'(mif.move_pop),   32'd0);
    mif.move_ack = 1'b1;
    tick();
    mif.move_ack = 1'b0;
    check("t1_ack_valid", 32'(mif.move_valid), 32'd0);
    check("t1_ack_sel",   32'(sel_valid),      32'd0);

    // 2: illegal keys and a bare submit in IDLE
    press_key(4'h9);
    check("t2_k9_err", 32'(err_pulse), 32'd1);
    check("t2_k9_sel", 32'(sel_valid), 32'd0);
    tick();
    check("t2_err_1clk", 32'(err_pulse), 32'd0);
    press_key(4'h0);
    check("t2_k0_err", 32'(err_pulse), 32'd1);
    check("t2_k0_sel", 32'(sel_valid), 32'd0);
    submit = 1'b1;
    tick();
    tick();
    check("t2_sub_err", 32'(err_pulse), 32'd1);
    submit = 1'b0;
    tick();
    check("t2_sub_err_end", 32'(err_pulse), 32'd0);

    // 3: reselect, pop move, then hold without ack while poking inputs
    press_key(4'h5);
    check("t3_sel_col5", 32'(sel_col), 32'd4);
    press_key(4'h2);
    check("t3_sel_col2", 32'(sel_col), 32'd1);
    pop_in = 1'b1;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check("t3_valid", 32'(mif.move_valid), 32'd1);
    check("t3_col",   32'(mif.move_col),   32'd1);
    check("t3_pop",   32'(mif.move_pop),   32'd1);
    for (int i = 0; i < 10; i++) begin
      key_code   = (i % 2 == 1) ? 4'h4 : 4'hA;
      key_strobe = 1'b1;
      submit     = (i % 2 == 0);
      pop_in     = ~pop_in;
      tick();
      check("t3_hold_valid", 32'(mif.move_valid), 32'd1);
      check("t3_hold_col",   32'(mif.move_col),   32'd1);
      check("t3_hold_pop",   32'(mif.move_pop),   32'd1);
      check("t3_hold_err",   32'(err_pulse),      32'd0);
    end
    key_strobe   = 1'b0;
    submit       = 1'b0;
    pop_in       = 1'b0;
    mif.move_ack = 1'b1;
    tick();
    mif.move_ack = 1'b0;
    check("t3_ack_valid", 32'(mif.move_valid), 32'd0);
    check("t3_ack_sel",   32'(sel_valid),      32'd0);
    check("t3_ack_err",   32'(err_pulse),      32'd0);
    tick();

    // 4: submit held from before the key never fires; re-press does
    submit = 1'b1;
    tick();
    tick();
    tick();
    press_key(4'h7);
    check("t4_sel_col", 32'(sel_col), 32'd6);
    tick();
    tick();
    check("t4_held_no_move", 32'(mif.move_valid), 32'd0);
    check("t4_held_sel",     32'(sel_valid),      32'd1);
    submit = 1'b0;
    tick();
    submit = 1'b1;
    tick();
    tick();
    submit = 1'b0;
    check("t4_valid", 32'(mif.move_valid), 32'd1);
    check("t4_col",   32'(mif.move_col),   32'd6);
    check("t4_pop",   32'(mif.move_pop),   32'd0);
    mif.move_ack = 1'b1;
    tick();
    mif.move_ack = 1'b0;
    check("t4_ack_valid", 32'(mif.move_valid), 32'd0);
    press_key(4'h3);
    mif.game_ready = 1'b0;
    submit = 1'b1;
    tick();
    tick();
    check("t4_nr_err",   32'(err_pulse),      32'd1);
    check("t4_nr_sel",   32'(sel_valid),      32'd1);
    check("t4_nr_valid", 32'(mif.move_valid), 32'd0);
    tick();
    check("t4_nr_err_end", 32'(err_pulse), 32'd0);
    check("t4_nr_col",     32'(sel_col),   32'd2);
    submit = 1'b0;
    tick();

    // 5: key in the submit cycle is dropped; reset in REQ kills the move
    press_key(4'h5);
    check("t5_sel_col", 32'(sel_col), 32'd4);
    mif.game_ready = 1'b1;
    submit = 1'b1;
    tick();
    key_code   = 4'h1;
    key_strobe = 1'b1;
    tick();
    key_strobe = 1'b0;
    check("t5_valid",   32'(mif.move_valid), 32'd1);
    check("t5_col",     32'(mif.move_col),   32'd4);
    check("t5_sel_col", 32'(sel_col),        32'd4);
    submit = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(mif.move_valid), 32'd0);
    check("t5_rst_sel",   32'(sel_valid),      32'd0);
    tick();
    tick();
    clr_n = 1'b1;
    mif.move_ack = 1'b1;
    tick();
    tick();
    mif.move_ack = 1'b0;
    check("t5_idle_ack_valid", 32'(mif.move_valid), 32'd0);
    check("t5_idle_ack_sel",   32'(sel_valid),      32'd0);
    check("t5_idle_ack_err",   32'(err_pulse),      32'd0);

    // 6: selection lifetime
`ifdef SELECT_TIMEOUT_EN
    press_key(4'h2);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t6_alive", 32'(sel_valid), 32'd1);
    end
    tick();
    check("t6_expire_sel", 32'(sel_valid), 32'd0);
    check("t6_expire_err", 32'(err_pulse), 32'd1);
    tick();
    press_key(4'h2);
    tick();
    tick();
    tick();
    tick();
    press_key(4'h2);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t6_restart_alive", 32'(sel_valid), 32'd1);
      check("t6_restart_noerr", 32'(err_pulse), 32'd0);
    end
    tick();
    check("t6_restart_expire_sel", 32'(sel_valid), 32'd0);
    check("t6_restart_expire_err", 32'(err_pulse), 32'd1);
`else
    press_key(4'h2);
    repeat (30) tick();
    check("t6_hold_sel", 32'(sel_valid), 32'd1);
    check("t6_hold_col", 32'(sel_col),   32'd1);
    check("t6_hold_err", 32'(err_pulse), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
